// File: rtl/invsubbytes_seq_pkg.sv
// Shared definitions for the sequenced InvSubBytes engine.
// Holds the FSM state encoding and the AES state geometry used by the
// top level and the bench.
package invsubbytes_seq_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/invsubbytes_seq_invsubbyte.sv
// Single-byte AES inverse S-box lookup (purely combinational).
// Ports:
//   in_byte  - byte to substitute
//   out_byte - InvSbox(in_byte)
module invsubbyte (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/invsubbytes_seq.sv
// Sequenced InvSubBytes engine: accepts a 128-bit AES state, substitutes
// LANES bytes per cycle through shared inverse S-box lanes, and returns the
// result over a valid/ready handshake.
// Ports:
//   clk, rst   - clock (rising edge), async active-high reset
//   in_state   - input state, byte i = in_state[8i+7:8i]
//   in_valid   - in_state valid
//   in_ready   - engine can accept a state (IDLE)
//   out_state  - substituted state, defined while out_valid is high
//   out_valid  - out_state valid (DONE)
//   out_ready  - consumer takes out_state
//   busy       - high in RUN or DONE
module invsubbytes_seq
    import invsubbytes_seq_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AES_STATE_W-1:0] in_state,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int unsigned STEPS = AES_BYTES / LANES;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       step;
    logic [AES_STATE_W-1:0] in_reg;
    logic [7:0]             lane_in  [LANES];
    logic [7:0]             lane_out [LANES];

    // Any counter value past the last step is treated as the last step.
    always_comb begin
        step = (cnt >= LAST) ? LAST : cnt;
    end

    // Lane j reads byte step*LANES+j of the registered input.
    always_comb begin
        for (int unsigned j = 0; j < LANES; j++) begin
            lane_in[j] = in_reg[8*(32'(step)*LANES + j) +: 8];
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        invsubbyte u_invsubbyte (
            .in_byte  (lane_in[j]),
            .out_byte (lane_out[j])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_reg    <= '0;
            out_state <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_reg   <= in_state;
                        cnt      <= '0;
                        state    <= RUN;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    for (int unsigned j = 0; j < LANES; j++) begin
                        out_state[8*(32'(step)*LANES + j) +: 8] <= lane_out[j];
                    end
                    if (step == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_invsubbytes_seq.sv
// Directed bench for invsubbytes_seq: one instance per legal LANES value
// (1,2,4,8,16) on shared inputs; most scenarios target the LANES=4 instance.
module tb_invsubbytes_seq;

    localparam int N = 5;
    localparam int M = 2;   // index of the LANES=4 instance

    localparam logic [127:0] VEC    = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] E_VEC  = 128'hfbd7f3819ea340bf38a53630d56a0952;
    localparam logic [127:0] E_ZERO = {16{8'h52}};
    localparam logic [127:0] E_FF   = {16{8'h7d}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] in_state = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;

    logic [127:0] out_s [N];
    logic         rdy [N];
    logic         ov  [N];
    logic         bsy [N];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        invsubbytes_seq #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_state  (in_state),
            .in_valid  (in_valid),
            .in_ready  (rdy[g]),
            .out_state (out_s[g]),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .busy      (bsy[g])
        );
    end

    function automatic logic all_idle();
        logic r = 1'b1;
        for (int g = 0; g < N; g++) r &= rdy[g];
        return r;
    endfunction

    task automatic wait_all_idle();
        int n = 0;
        out_ready = 1'b1;
        while (!all_idle() && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL idle_timeout: waited %0d cycles, required all in_ready=1", n);
        end
    endtask

    // Hand one state to the LANES=4 instance; lat = cycles from accepting edge to out_valid, -1 on timeout.
    task automatic accept(input logic [127:0] d, output int lat);
        int n = 0;
        while (!rdy[M] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        in_state = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (ov[M] === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ov[M] !== 1'b0 || bsy[M] !== 1'b0 || out_s[M] !== '0) begin
            failures++;
            $display("FAIL reset_outputs: out_valid=%b busy=%b out_state=%h, required 0 0 0", ov[M], bsy[M], out_s[M]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy[M] !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b, required 1", rdy[M]);
        end
    endtask

    task automatic test_idle_hold();
        logic bad = 1'b0;
        in_valid = 1'b0;
        in_state = VEC;
        repeat (5) begin
            @(posedge clk); #1;
            if (bsy[M] !== 1'b0 || rdy[M] !== 1'b1 || ov[M] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL idle_hold: busy=%b in_ready=%b out_valid=%b, required 0 1 0", bsy[M], rdy[M], ov[M]);
        end
    endtask

    task automatic test_zero();
        int lat;
        wait_all_idle();
        accept('0, lat);
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL zero_latency: got %0d, required 4", lat);
        end
        checks++;
        if (out_s[M] !== E_ZERO) begin
            failures++;
            $display("FAIL zero_data: got %h, required %h", out_s[M], E_ZERO);
        end
    endtask

    task automatic test_vector();
        int lat;
        wait_all_idle();
        accept(VEC, lat);
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL vec_latency: got %0d, required 4", lat);
        end
        checks++;
        if (out_s[M] !== E_VEC) begin
            failures++;
            $display("FAIL vec_data: got %h, required %h", out_s[M], E_VEC);
        end
    endtask

    task automatic test_63_ff();
        logic [127:0] din [2];
        logic [127:0] exp_out [2];
        din[0] = {16{8'h63}};
        din[1] = {16{8'hff}};
        exp_out[0] = '0;
        exp_out[1] = E_FF;
        wait_all_idle();
        for (int t = 0; t < 2; t++) begin
            logic bad_rdy = 1'b0;
            logic bad_busy = 1'b0;
            int lat = -1;
            while (!rdy[M]) begin
                @(posedge clk); #1;
            end
            in_state = din[t];
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int c = 1; c <= 40; c++) begin
                if (rdy[M] !== 1'b0) bad_rdy = 1'b1;
                if (bsy[M] !== 1'b1) bad_busy = 1'b1;
                @(posedge clk); #1;
                if (ov[M] === 1'b1) begin
                    lat = c;
                    if (rdy[M] !== 1'b0) bad_rdy = 1'b1;
                    break;
                end
            end
            checks++;
            if (lat != 4 || bad_rdy || bad_busy) begin
                failures++;
                $display("FAIL run_flags[%0d]: latency=%0d ready_seen_high=%b busy_seen_low=%b, required 4 0 0", t, lat, bad_rdy, bad_busy);
            end
            checks++;
            if (out_s[M] !== exp_out[t]) begin
                failures++;
                $display("FAIL subst_data[%0d]: got %h, required %h", t, out_s[M], exp_out[t]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic bad = 1'b0;
        logic [127:0] snap;
        wait_all_idle();
        out_ready = 1'b0;
        accept(VEC, lat);
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL bp_latency: got %0d, required 4", lat);
        end
        snap = out_s[M];
        in_state = ~VEC;
        in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (ov[M] !== 1'b1 || out_s[M] !== E_VEC || rdy[M] !== 1'b0 || out_s[M] !== snap) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL bp_hold: out_valid=%b in_ready=%b out_state=%h, required 1 0 %h", ov[M], rdy[M], out_s[M], E_VEC);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ov[M] !== 1'b0 || rdy[M] !== 1'b1 || bsy[M] !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b, required 0 1 0", ov[M], rdy[M], bsy[M]);
        end
        checks++;
        if (out_s[M] !== E_VEC) begin
            failures++;
            $display("FAIL bp_idle_keep: got %h, required %h", out_s[M], E_VEC);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        wait_all_idle();
        in_state = {16{8'hff}};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (bsy[M] !== 1'b1) begin
            failures++;
            $display("FAIL mid_run_busy: got %b, required 1", bsy[M]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ov[M] !== 1'b0 || bsy[M] !== 1'b0 || out_s[M] !== '0) begin
            failures++;
            $display("FAIL mid_run_reset: out_valid=%b busy=%b out_state=%h, required 0 0 0", ov[M], bsy[M], out_s[M]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        accept(VEC, lat);
        checks++;
        if (lat != 4 || out_s[M] !== E_VEC) begin
            failures++;
            $display("FAIL post_reset: latency=%0d out_state=%h, required 4 %h", lat, out_s[M], E_VEC);
        end
    endtask

    task automatic test_lanes_sweep();
        int lat [N];
        logic [127:0] got [N];
        wait_all_idle();
        for (int g = 0; g < N; g++) begin
            lat[g] = -1;
            got[g] = '0;
        end
        in_state = VEC;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            for (int g = 0; g < N; g++) begin
                if (lat[g] < 0 && ov[g] === 1'b1) begin
                    lat[g] = c;
                    got[g] = out_s[g];
                end
            end
        end
        for (int g = 0; g < N; g++) begin
            checks++;
            if (lat[g] != (16 >> g)) begin
                failures++;
                $display("FAIL sweep_latency[LANES=%0d]: got %0d, required %0d", 1 << g, lat[g], 16 >> g);
            end
            checks++;
            if (got[g] !== E_VEC) begin
                failures++;
                $display("FAIL sweep_data[LANES=%0d]: got %h, required %h", 1 << g, got[g], E_VEC);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_zero();
        test_vector();
        test_63_ff();
        test_backpressure();
        test_reset_mid_run();
        test_lanes_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/invsubbytes_seq.md
Name: invsubbytes_seq

Overview:
- Sequenced InvSubBytes engine for the AES-128 decrypt datapath.
- Accepts a 128-bit state over a valid/ready handshake and time-multiplexes LANES inverse S-box instances across the 16 state bytes.
- Returns the substituted state over a second valid/ready handshake.
- Sits between the InvShiftRows and AddRoundKey stages of the decrypt round logic; lets area be traded against latency.

Parameters:
- LANES, 4, number of parallel inverse S-box instances; legal values 1, 2, 4, 8, 16.
- STEPS, 16/LANES, derived (localparam), cycles per state.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_state  input  128  state to substitute; byte i = in_state[8i+7:8i].
- in_valid  input  1  in_state is valid.
- in_ready  output  1  block can accept a state.
- out_state  output  128  substituted state; byte i = InvSbox(in byte i).
- out_valid  output  1  out_state is valid.
- out_ready  input  1  consumer accepts out_state.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst=1): FSM=IDLE; out_state=0, out_valid=0, busy=0, step counter=0, internal input register=0; in_ready=1 once rst deasserts.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register in_state, clear counter, go to RUN.
  - out_state keeps its previous value.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle at counter k: lane j looks up byte k*LANES+j of the registered input; the result is written into the same byte of out_state.
  - Counter increments.
  - When k=STEPS-1, go to DONE after that write.
- DONE:
  - out_valid=1, busy=1, in_ready=0; out_state stable.
  - On out_ready go to IDLE and clear out_valid.
- Latency: out_valid rises exactly STEPS cycles after the accepting edge (LANES=16 gives 1 cycle; LANES=1 gives 16).
- Throughput: one state per STEPS+2 cycles with out_ready held high. No accept during DONE, so there is one bubble cycle in IDLE.
- in_valid deasserted in IDLE: stay in IDLE, no state change.
- in_state changes during RUN: ignored, because the input is registered at accept.
- out_ready held low in DONE: hold indefinitely; out_state and out_valid must not change.
- out_ready high outside DONE: no effect.
- rst mid-RUN or mid-DONE: immediate return to the reset values; the partial result is discarded.
- Counter width is clog2(STEPS), minimum 1 bit. It must not wrap past STEPS-1; any out-of-range value is treated as the final step.
- Bytes not yet written in RUN hold their old value. Only the DONE contents are defined.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - AES_STATE_W=128;
  - AES_BYTES=16.
- Sub-module: the existing invsubbyte lookup, instantiated LANES times via a generate loop.
- Each lane's input comes from a byte mux indexed by the counter. No new sub-module is required.

Test Plan:
- LANES=4, in_state=0, out_ready=1 -> out_state=128'h5252...52 (all 16 bytes 0x52); out_valid rises 4 cycles after accept.
- LANES=4, in_state=128'h0f0e0d0c0b0a09080706050403020100 -> out_state=128'hfbd7f3819ea340bf38a53630d56a0952.
- LANES=4, all bytes 0x63 -> out_state=0. Then drive all bytes 0xff -> all bytes 0x7d; in_ready=0 throughout RUN/DONE.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid=1 and out_state constant. A new in_valid during DONE is not accepted (in_ready=0).
- Assert rst for 1 cycle at RUN step 2 -> out_valid=0, busy=0, out_state=0 immediately. A following new state completes correctly.
- Sweep LANES=1,2,8,16 on the same vector as scenario 2 -> identical out_state; latency 16/8/2/1 cycles respectively.
